// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// registered fetch-to-decode payload with a one-entry skid and redirect handling.
package fetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc_plus_4;
  } f_d_reg_t;
endpackage

module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output f_d_reg_t    f_d_reg
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] req_pc, req_pc_nx;
  f_d_reg_t    fd_nx;
  logic        skid_valid, skid_valid_nx;
  logic [31:0] skid_instr, skid_instr_nx;
  logic [31:0] skid_pc4, skid_pc4_nx;
  logic        writable;
  logic [31:0] pc_plus_4;

  assign writable   = !f_d_reg.valid || !stall;
  assign pc_plus_4  = pc + 32'd4;
  assign ireq_valid = !reset && (state != HOLD);
  // DROP keeps presenting the abandoned address until its response drains
  assign ireq_addr  = (state == DROP) ? req_pc : pc;

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    req_pc_nx     = req_pc;
    fd_nx         = f_d_reg;
    skid_valid_nx = skid_valid;
    skid_instr_nx = skid_instr;
    skid_pc4_nx   = skid_pc4;
    if (!stall) fd_nx.valid = 1'b0;

    if (redirect_valid) begin
      fd_nx.valid   = 1'b0;
      skid_valid_nx = 1'b0;
      pc_nx         = redirect_pc;
      unique case (state)
        FETCH: if (!iresp_valid) begin
          req_pc_nx = pc;
          state_nx  = DROP;
        end
        HOLD:    state_nx = FETCH;
        DROP:    if (iresp_valid) state_nx = FETCH;
        default: state_nx = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: if (iresp_valid) begin
          pc_nx = pc_plus_4;
          if (writable) begin
            fd_nx = '{valid: 1'b1, instruction: iresp_data, pc_plus_4: pc_plus_4};
          end else begin
            skid_valid_nx = 1'b1;
            skid_instr_nx = iresp_data;
            skid_pc4_nx   = pc_plus_4;
            state_nx      = HOLD;
          end
        end
        HOLD: if (!stall) begin
          fd_nx         = '{valid: skid_valid, instruction: skid_instr, pc_plus_4: skid_pc4};
          skid_valid_nx = 1'b0;
          state_nx      = FETCH;
        end
        DROP:    if (iresp_valid) state_nx = FETCH;
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      f_d_reg    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      req_pc     <= req_pc_nx;
      f_d_reg    <= fd_nx;
      skid_valid <= skid_valid_nx;
      skid_instr <= skid_instr_nx;
      skid_pc4   <= skid_pc4_nx;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: a queue-based model of buffered instructions and
// the outstanding request predicts the DUT outputs every cycle.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  f_d_reg_t    f_d_reg;

  int total = 0;
  int bad = 0;

  fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .f_d_reg(f_d_reg)
  );

  always #5 clk = ~clk;

  // Model: queue of delivered-but-unconsumed instructions (front is on f_d_reg),
  // the program-order next address, and an abandoned request still in flight.
  logic [31:0] q_instr[$];
  logic [31:0] q_pc4[$];
  logic [31:0] m_next_pc = RESET_PC;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_addr = '0;
  bit          m_rst = 1'b1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic bit m_ireq_valid();
    return !m_rst && (q_instr.size() < 2);
  endfunction

  function automatic logic [31:0] m_ireq_addr();
    return m_stale ? m_stale_addr : m_next_pc;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_instr.delete();
    q_pc4.delete();
    m_next_pc = RESET_PC;
    m_stale   = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit rv, input logic [31:0] rpc, input bit rsp);
    bit issued;
    bit r;
    issued = m_ireq_valid();
    r = issued && rsp;
    if (rv) begin
      if (r) m_stale = 1'b0;
      else if (!m_stale && issued) begin
        m_stale      = 1'b1;
        m_stale_addr = m_next_pc;
      end
      q_instr.delete();
      q_pc4.delete();
      m_next_pc = rpc;
    end else begin
      if (q_instr.size() > 0 && !st) begin
        void'(q_instr.pop_front());
        void'(q_pc4.pop_front());
      end
      if (r) begin
        if (m_stale) m_stale = 1'b0;
        else begin
          q_instr.push_back(mem(m_next_pc));
          q_pc4.push_back(m_next_pc + 32'd4);
          m_next_pc = m_next_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic compare();
    chk("ireq_valid", {31'd0, ireq_valid}, {31'd0, m_ireq_valid()});
    if (m_ireq_valid()) chk("ireq_addr", ireq_addr, m_ireq_addr());
    chk("fd_valid", {31'd0, f_d_reg.valid}, {31'd0, q_instr.size() > 0});
    if (q_instr.size() > 0) begin
      chk("fd_instr", f_d_reg.instruction, q_instr[0]);
      chk("fd_pc4", f_d_reg.pc_plus_4, q_pc4[0]);
    end
  endtask

  // Called at a negedge; drives inputs, lets one rising edge pass, checks at next negedge.
  task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input int resp_pct);
    logic [31:0] noise;
    noise          = $urandom;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_valid    = ($urandom_range(0, 99) < resp_pct);
    iresp_data     = ireq_valid ? mem(ireq_addr) : noise;
    @(posedge clk);
    model_step(st, rv, rpc, iresp_valid);
    @(negedge clk);
    compare();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    m_rst = 1'b0;
    #1;
    chk("post_rst_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    chk("post_rst_ireq_addr", ireq_addr, 32'hBFC0_0000);
    compare();
  endtask

  // Asserts reset between edges and checks the outputs react without a clock.
  task automatic async_reset();
    stall = 1'b0; redirect_valid = 1'b0; iresp_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    chk("async_rst_fd_valid", {31'd0, f_d_reg.valid}, 32'd0);
    chk("async_rst_fd_instr", f_d_reg.instruction, 32'd0);
    chk("async_rst_ireq_addr", ireq_addr, 32'hBFC0_0000);
    model_reset();
    m_rst = 1'b1;
    iresp_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_late_resp_ignored", {31'd0, f_d_reg.valid}, 32'd0);
    iresp_valid = 1'b0;
    release_reset();
  endtask

  initial begin
    int stall_pct, resp_pct, redir_pct;
    logic [31:0] tmp, rpc;

    repeat (3) @(negedge clk);
    chk("rst_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    chk("rst_fd_valid", {31'd0, f_d_reg.valid}, 32'd0);
    chk("rst_fd_instr", f_d_reg.instruction, 32'd0);
    chk("rst_fd_pc4", f_d_reg.pc_plus_4, 32'd0);
    chk("rst_ireq_addr", ireq_addr, 32'hBFC0_0000);
    model_reset();
    release_reset();

    // zero-wait stream
    step(0, 0, '0, 100);
    chk("stream0_instr", f_d_reg.instruction, mem(32'hBFC0_0000));
    chk("stream0_pc4", f_d_reg.pc_plus_4, 32'hBFC0_0004);
    step(0, 0, '0, 100);
    chk("stream1_instr", f_d_reg.instruction, mem(32'hBFC0_0004));
    chk("stream1_pc4", f_d_reg.pc_plus_4, 32'hBFC0_0008);
    step(0, 0, '0, 100);
    step(0, 0, '0, 100);

    // stall for 3 cycles after the first valid output
    async_reset();
    step(0, 0, '0, 100);
    step(1, 0, '0, 100);
    chk("stall_hold_pc4", f_d_reg.pc_plus_4, 32'hBFC0_0004);
    chk("stall_hold_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    step(1, 0, '0, 100);
    step(1, 0, '0, 100);
    step(0, 0, '0, 100);
    chk("stall_release_pc4", f_d_reg.pc_plus_4, 32'hBFC0_0008);
    chk("stall_release_instr", f_d_reg.instruction, mem(32'hBFC0_0004));
    step(0, 0, '0, 100);
    chk("stall_next_pc4", f_d_reg.pc_plus_4, 32'hBFC0_000C);

    // redirect while a slow response is pending
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 1, 32'h8000_0100, 0);
    chk("drop_addr_held", ireq_addr, 32'hBFC0_000C);
    chk("drop_fd_valid", {31'd0, f_d_reg.valid}, 32'd0);
    step(0, 0, '0, 0);
    chk("drop_addr_held2", ireq_addr, 32'hBFC0_000C);
    step(0, 0, '0, 100);
    chk("drop_discard_fd_valid", {31'd0, f_d_reg.valid}, 32'd0);
    chk("drop_next_addr", ireq_addr, 32'h8000_0100);
    step(0, 0, '0, 100);
    chk("redir_target_pc4", f_d_reg.pc_plus_4, 32'h8000_0104);

    // redirect together with response and stall
    step(1, 1, 32'h0000_1000, 100);
    chk("redir_resp_stall_fd_valid", {31'd0, f_d_reg.valid}, 32'd0);
    chk("redir_resp_stall_addr", ireq_addr, 32'h0000_1000);

    // wrap-around
    step(0, 1, 32'hFFFF_FFFC, 100);
    step(0, 0, '0, 100);
    chk("wrap_pc4", f_d_reg.pc_plus_4, 32'h0000_0000);
    chk("wrap_addr", ireq_addr, 32'h0000_0000);

    // async reset while in DROP
    step(0, 1, 32'h4000_0000, 0);
    async_reset();

    stall_pct = 0; resp_pct = 100; redir_pct = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        stall_pct = $urandom_range(0, 70);
        resp_pct  = $urandom_range(20, 100);
        redir_pct = $urandom_range(0, 15);
      end
      if (c % 700 == 350) async_reset();
      tmp = $urandom;
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {tmp[31:2], 2'b00};
      step($urandom_range(0, 99) < stall_pct, $urandom_range(0, 99) < redir_pct, rpc, resp_pct);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
